// File: rtl/prom_arb.sv
// Two-port read arbiter in front of a synchronous PROM: issues at most one read
// per cycle and returns data on the granted port a fixed two cycles after its ack.
module prom_arb #(
    parameter int unsigned ADR_W = 9,
    parameter int unsigned DAT_W = 32,
    parameter int unsigned RR    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic [ADR_W-1:0] a_adr,
    input  logic             b_req,
    input  logic [ADR_W-1:0] b_adr,
    output logic             a_ack,
    output logic             b_ack,
    output logic             a_vld,
    output logic             b_vld,
    output logic [DAT_W-1:0] a_data,
    output logic [DAT_W-1:0] b_data,
    output logic [ADR_W-1:0] rom_adr,
    input  logic [DAT_W-1:0] rom_data
);

    logic             grant_a;
    logic             grant_b;
    logic             last_b_q;
    logic             last_b_d;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] adr_d;
    logic [1:0]       tag_q;
    logic [1:0]       tag_d;
    logic             a_vld_q;
    logic             b_vld_q;
    logic [DAT_W-1:0] a_data_q;
    logic [DAT_W-1:0] b_data_q;

    // last_b_q set means B won the most recent grant, so A wins the next contention
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                if ((RR != 0) && !last_b_q) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    always_comb begin
        adr_d    = adr_q;
        last_b_d = last_b_q;
        if (grant_a) begin
            adr_d    = a_adr;
            last_b_d = 1'b0;
        end else if (grant_b) begin
            adr_d    = b_adr;
            last_b_d = 1'b1;
        end
        tag_d = {grant_b, grant_a};
    end

    assign rom_adr = adr_d;
    assign a_ack   = grant_a;
    assign b_ack   = grant_b;
    assign a_vld   = a_vld_q;
    assign b_vld   = b_vld_q;
    assign a_data  = a_data_q;
    assign b_data  = b_data_q;

    // tag_q marks the read whose PROM word is on rom_data this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b_q <= 1'b1;
            adr_q    <= '0;
            tag_q    <= '0;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            last_b_q <= last_b_d;
            adr_q    <= adr_d;
            tag_q    <= tag_d;
            a_vld_q  <= tag_q[0];
            b_vld_q  <= tag_q[1];
            if (tag_q[0]) begin
                a_data_q <= rom_data;
            end
            if (tag_q[1]) begin
                b_data_q <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_prom_arb.sv
// Scoreboard bench for prom_arb: one round-robin and one fixed-priority instance
// driven from per-port address plans and checked against a rule-level model.
module tb_prom_arb;

    localparam int ADR_W = 9;
    localparam int DAT_W = 32;
    localparam int DEPTH = 1 << ADR_W;

    typedef struct {
        int             dut;
        int             port;
        logic [DAT_W-1:0] data;
        int             due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             a_req    [2];
    logic             b_req    [2];
    logic [ADR_W-1:0] a_adr    [2];
    logic [ADR_W-1:0] b_adr    [2];
    logic             a_ack    [2];
    logic             b_ack    [2];
    logic             a_vld    [2];
    logic             b_vld    [2];
    logic [DAT_W-1:0] a_data   [2];
    logic [DAT_W-1:0] b_data   [2];
    logic [ADR_W-1:0] rom_adr  [2];
    logic [DAT_W-1:0] rom_data [2];

    logic [DAT_W-1:0] mem [DEPTH];

    prom_arb #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RR(1)) dut_rr (
        .clk(clk), .rst(rst),
        .a_req(a_req[0]), .a_adr(a_adr[0]), .b_req(b_req[0]), .b_adr(b_adr[0]),
        .a_ack(a_ack[0]), .b_ack(b_ack[0]), .a_vld(a_vld[0]), .b_vld(b_vld[0]),
        .a_data(a_data[0]), .b_data(b_data[0]),
        .rom_adr(rom_adr[0]), .rom_data(rom_data[0])
    );

    prom_arb #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RR(0)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(a_req[1]), .a_adr(a_adr[1]), .b_req(b_req[1]), .b_adr(b_adr[1]),
        .a_ack(a_ack[1]), .b_ack(b_ack[1]), .a_vld(a_vld[1]), .b_vld(b_vld[1]),
        .a_data(a_data[1]), .b_data(b_data[1]),
        .rom_adr(rom_adr[1]), .rom_data(rom_data[1])
    );

    // Synchronous PROM: word appears the cycle after its address is sampled
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) rom_data[k] <= mem[rom_adr[k]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Per-port plan of addresses to read (index dut*2+port); -1 = one idle cycle
    int   plan [4][$];
    exp_t sbq[$];
    bit               last_b   [2];
    logic [ADR_W-1:0] last_adr [2];
    logic [DAT_W-1:0] hold     [2][2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        sbq.delete();
        for (int k = 0; k < 2; k++) begin
            last_b[k]   = 1'b1;
            last_adr[k] = '0;
            hold[k][0]  = '0;
            hold[k][1]  = '0;
        end
    endtask

    // Reference model: grant rules, expected acks/rom_adr, and scoreboard pushes
    bit   ga_m, gb_m;
    logic [ADR_W-1:0] gadr_m;
    exp_t e_m;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                check($sformatf("rst_a_ack[%0d]", k), 64'(a_ack[k]), 64'(0));
                check($sformatf("rst_b_ack[%0d]", k), 64'(b_ack[k]), 64'(0));
                check($sformatf("rst_rom_adr[%0d]", k), 64'(rom_adr[k]), 64'(0));
            end else begin
                ga_m = a_req[k] && (!b_req[k] || (k == 1) || last_b[k]);
                gb_m = b_req[k] && !ga_m;
                check($sformatf("a_ack[%0d]", k), 64'(a_ack[k]), 64'(ga_m));
                check($sformatf("b_ack[%0d]", k), 64'(b_ack[k]), 64'(gb_m));
                gadr_m = ga_m ? a_adr[k] : (gb_m ? b_adr[k] : last_adr[k]);
                check($sformatf("rom_adr[%0d]", k), 64'(rom_adr[k]), 64'(gadr_m));
                if (ga_m || gb_m) begin
                    e_m.dut  = k;
                    e_m.port = gb_m ? 1 : 0;
                    e_m.data = mem[gadr_m];
                    e_m.due  = cyc + 2;
                    sbq.push_back(e_m);
                    last_b[k]   = gb_m;
                    last_adr[k] = gadr_m;
                    void'(plan[k*2 + e_m.port].pop_front());
                end
            end
        end
    end

    // Monitor: pop the read due this cycle for each port and compare vld/data
    bit               ev;
    logic [DAT_W-1:0] ed;
    logic             vld_s;
    logic [DAT_W-1:0] dat_s;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                ev = 1'b0;
                ed = '0;
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].dut == k && sbq[i].port == p && sbq[i].due == cyc) begin
                        ev = 1'b1;
                        ed = sbq[i].data;
                        sbq.delete(i);
                        break;
                    end
                end
                vld_s = (p == 0) ? a_vld[k] : b_vld[k];
                dat_s = (p == 0) ? a_data[k] : b_data[k];
                check($sformatf("vld[%0d][%0d]", k, p), 64'(vld_s), 64'(ev));
                if (ev) begin
                    check($sformatf("data[%0d][%0d]", k, p), 64'(dat_s), 64'(ed));
                    hold[k][p] = ed;
                end else begin
                    check($sformatf("hold[%0d][%0d]", k, p), 64'(dat_s), 64'(hold[k][p]));
                end
            end
        end
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            check($sformatf("missing_vld[%0d][%0d]", sbq[0].dut, sbq[0].port), 64'(0), 64'(1));
            void'(sbq.pop_front());
        end
    end

    task automatic drive_port(input int k, input int p);
        int idx;
        int v;
        idx = k*2 + p;
        if (p == 0) a_req[k] = 1'b0; else b_req[k] = 1'b0;
        if (plan[idx].size() > 0) begin
            v = plan[idx][0];
            if (v < 0) begin
                void'(plan[idx].pop_front());
            end else if (p == 0) begin
                a_req[k] = 1'b1;
                a_adr[k] = ADR_W'(v);
            end else begin
                b_req[k] = 1'b1;
                b_adr[k] = ADR_W'(v);
            end
        end
    endtask

    task automatic run_cycle(input bit r);
        @(posedge clk);
        #1;
        rst = r;
        if (r) reset_model();
        for (int k = 0; k < 2; k++) begin
            drive_port(k, 0);
            drive_port(k, 1);
        end
    endtask

    task automatic push_both(input int p, input int v);
        plan[p].push_back(v);
        plan[2 + p].push_back(v);
    endtask

    function automatic bit plans_busy();
        return plan[0].size() > 0 || plan[1].size() > 0 || plan[2].size() > 0 || plan[3].size() > 0;
    endfunction

    task automatic run_until_idle(input bit allow_rst);
        int guard;
        guard = 0;
        while (plans_busy() && guard < 2000) begin
            run_cycle(allow_rst && ($urandom_range(0, 60) == 0));
            guard++;
        end
        if (plans_busy()) begin
            check("plan_timeout", 64'(guard), 64'(0));
            for (int i = 0; i < 4; i++) plan[i].delete();
        end
        repeat (4) run_cycle(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5] = 32'h1234_5678;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a_req[k] = 1'b0;
            b_req[k] = 1'b0;
            a_adr[k] = '0;
            b_adr[k] = '0;
        end
        reset_model();
        repeat (3) run_cycle(1'b1);

        // single read of word 5
        push_both(0, 5);
        run_until_idle(1'b0);

        // contention from reset: A wins first, then RR alternates / FP starves B
        run_cycle(1'b1);
        for (int i = 0; i < 4; i++) push_both(0, 1);
        push_both(1, 2);
        push_both(1, 2);
        run_until_idle(1'b0);

        // back-to-back on A
        push_both(0, 10);
        push_both(0, 11);
        push_both(0, 12);
        run_until_idle(1'b0);

        // reset in the cycle after an ack drops that read
        push_both(0, 20);
        run_cycle(1'b0);
        run_cycle(1'b1);
        run_cycle(1'b0);
        push_both(0, 21);
        run_until_idle(1'b0);

        // identical simultaneous addresses
        push_both(0, 7);
        push_both(1, 7);
        run_until_idle(1'b0);

        // randomized traffic with idle gaps and occasional resets
        for (int round = 0; round < 40; round++) begin
            for (int p = 0; p < 2; p++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int j = 0; j < n; j++) begin
                    if ($urandom_range(0, 2) == 0) push_both(p, -1);
                    else push_both(p, int'($urandom_range(0, DEPTH - 1)));
                end
            end
            run_until_idle(1'b1);
        end

        check("sb_empty", 64'(sbq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
